gc_ctrl: RTL and testbench
==========================

GC_CTRL -- requirements
Module: gc_ctrl

Interface
REQ-001 SHALL have parameter GC_THRESHOLD, default 16: GC starts when the free-block count is below this value.
REQ-002 SHALL use nvm_pkg parameters BLOCK_W=10, PAGE_W=6, BLOCK_NUM=1024 and PAGE_NUM=64 for all widths.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port free_blocks, input, BLOCK_W+1 bits: current count of erased blocks.
REQ-006 SHALL have port open_block, input, BLOCK_W bits: the block currently open for host writes, never chosen as victim.
REQ-007 SHALL have port host_busy, input, 1 bit: a host flash operation is pending, so GC yields.
REQ-008 SHALL have port vc_addr, output, BLOCK_W bits: read address into the valid-count table.
REQ-009 SHALL have port vc_data, input, PAGE_W+1 bits: valid-page count for vc_addr, returned 1 cycle later.
REQ-010 SHALL have ports pv_block (output, BLOCK_W) and pv_page (output, PAGE_W): page-valid bitmap query address.
REQ-011 SHALL have port pv_valid, input, 1 bit: the queried page is valid, returned 1 cycle later.
REQ-012 SHALL have ports cmd_req (output, 1), cmd_op (output, 2: 01=MOVE, 10=ERASE), cmd_block (output, BLOCK_W) and cmd_page (output, PAGE_W): command to the flash controller.
REQ-013 SHALL have port cmd_ack, input, 1 bit: the flash controller accepted the command.
REQ-014 SHALL have ports gc_active (output, 1), gc_done (output, 1, one-cycle pulse), gc_fail (output, 1, one-cycle pulse) and victim (output, BLOCK_W).

Function
REQ-015 SHALL implement states IDLE, INI, INI_DONE, MOVE_START, INTERRUPT, ERASE and FINISH.
REQ-016 IDLE: SHALL go to INI when free_blocks < GC_THRESHOLD and host_busy=0; gc_active SHALL be high in every state except IDLE.
REQ-017 INI: SHALL sweep vc_addr 0..1023, one address per cycle, and compare vc_data one cycle later.
REQ-018 INI: SHALL skip open_block, keep the minimum count with ties going to the lowest index, and ignore host_busy; the scan lasts 1025 cycles.
REQ-019 INI_DONE: SHALL register victim; if the minimum count = PAGE_NUM, SHALL pulse gc_fail and go to IDLE, otherwise go to MOVE_START with page=0.
REQ-020 MOVE_START: SHALL drive pv_block=victim and pv_page=page, then sample pv_valid the next cycle.
REQ-021 MOVE_START: an invalid page SHALL cost 2 cycles; a valid page SHALL assert cmd_req with op=MOVE, block=victim and page=page on the cycle after pv_valid is sampled.
REQ-022 MOVE_START: after page 63 completes, SHALL go to ERASE (the page counter does not wrap).
REQ-023 Handshake: cmd_req and its fields SHALL stay stable until cmd_ack=1 is sampled, and cmd_req SHALL deassert the next cycle.
REQ-024 Handshake: cmd_ack while cmd_req=0 SHALL be ignored, and there SHALL be at most one outstanding command.
REQ-025 If host_busy=1 in MOVE_START with no command outstanding, SHALL go to INTERRUPT, hold the page counter, and re-query that page on return once host_busy=0.
REQ-026 If host_busy rises while a command is outstanding, SHALL complete that handshake first, then go to INTERRUPT.
REQ-027 ERASE: SHALL issue op=ERASE, block=victim, wait for cmd_ack, then go to FINISH; host_busy is honoured before issue, as in MOVE_START.
REQ-028 FINISH: SHALL pulse gc_done for 1 cycle, then go to IDLE; a rerun SHALL require a new threshold check.
REQ-029 SHALL compare free_blocks as an unsigned BLOCK_W+1-bit value; GC_THRESHOLD=0 SHALL disable GC.

Reset
REQ-030 rst SHALL force IDLE immediately, from any state including mid-handshake, without waiting for cmd_ack.
REQ-031 During and after reset, all outputs SHALL be 0: cmd_req, cmd_op, cmd_block, cmd_page, vc_addr, pv_block, pv_page, victim, gc_active, gc_done and gc_fail.
REQ-032 After reset, the min register SHALL be PAGE_NUM, and the page and block counters SHALL be 0.

Structure
REQ-033 gc_state_t (4-bit: IDLE 0, INTERRUPT 1, INI 2, INI_DONE 3, MOVE_START 4, FINISH 5, ERASE 6), the cmd_op encodings and the GC_THRESHOLD default SHALL live in nvm_pkg.
REQ-034 SHALL contain one sub-module, gc_victim_scan, holding the INI address counter and min-compare with tie rule.

Verification
REQ-035 Case: free_blocks=20, threshold 16 -> SHALL stay in IDLE with no vc_addr activity.
REQ-036 Case: free_blocks=15, counts all 64 except block 7=3 and block 9=3 -> SHALL select victim=7.
REQ-037 Case: continue REQ-036 with valid pages 0, 5 and 63 -> SHALL issue exactly three MOVEs (pages 0, 5, 63), then ERASE of block 7, then a gc_done pulse.
REQ-038 Case: host_busy=1 during page 5's handshake -> SHALL hold MOVE until ack, then enter INTERRUPT, then resume at page 6 once host_busy=0.
REQ-039 Case: all counts 64 and open_block=0 with count 0 -> SHALL pulse gc_fail and issue no command.
REQ-040 Case: rst during ERASE with cmd_req=1 -> SHALL drop cmd_req the same cycle, enter IDLE, and zero all outputs.

Source files
------------

// File: rtl/nvm_pkg.sv
// nvm_pkg: shared NVM geometry, GC state encoding, flash command opcodes and GC defaults.
package nvm_pkg;

    localparam int BLOCK_W   = 10;
    localparam int PAGE_W    = 6;
    localparam int BLOCK_NUM = 1024;
    localparam int PAGE_NUM  = 64;

    localparam int GC_THRESHOLD_DEF = 16;

    localparam logic [1:0] OP_MOVE  = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        INTERRUPT  = 4'd1,
        INI        = 4'd2,
        INI_DONE   = 4'd3,
        MOVE_START = 4'd4,
        FINISH     = 4'd5,
        ERASE      = 4'd6
    } gc_state_t;

    // Sub-steps of MOVE_START / ERASE: query the bitmap, look at the answer, hold a command.
    typedef enum logic [1:0] {
        PH_QUERY = 2'd0,
        PH_CHECK = 2'd1,
        PH_CMD   = 2'd2
    } gc_phase_t;

endpackage

// File: rtl/gc_victim_scan.sv
// gc_victim_scan: sweeps the valid-count table and tracks the emptiest block.
//   clk, rst    : clock, async active-high reset
//   en          : high while the controller is in INI; low clears the scan
//   open_block  : block excluded from selection
//   vc_data     : valid count for the address driven on the previous cycle
//   vc_addr     : table read address (0 when not scanning)
//   min_cnt     : lowest count seen so far (PAGE_NUM when nothing qualified)
//   min_idx     : block holding min_cnt, lowest index on ties
//   done        : last table entry is being compared this cycle
module gc_victim_scan
    import nvm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [BLOCK_W-1:0] open_block,
    input  logic [PAGE_W:0]    vc_data,
    output logic [BLOCK_W-1:0] vc_addr,
    output logic [PAGE_W:0]    min_cnt,
    output logic [BLOCK_W-1:0] min_idx,
    output logic               done
);
    logic [BLOCK_W:0]   addr_q, addr_d;
    logic [PAGE_W:0]    min_q, min_d;
    logic [BLOCK_W-1:0] idx_q, idx_d;
    logic [BLOCK_W-1:0] prev_addr;

    // vc_data always belongs to the address issued one cycle earlier.
    assign prev_addr = addr_q[BLOCK_W-1:0] - BLOCK_W'(1);
    assign vc_addr   = en ? addr_q[BLOCK_W-1:0] : '0;
    assign done      = addr_q == (BLOCK_W+1)'(BLOCK_NUM);
    assign min_cnt   = min_q;
    assign min_idx   = idx_q;

    always_comb begin
        addr_d = en ? addr_q + (BLOCK_W+1)'(1) : '0;
        min_d  = en ? min_q : (PAGE_W+1)'(PAGE_NUM);
        idx_d  = en ? idx_q : '0;
        // Strict less-than keeps the first (lowest-index) block on ties.
        if (en && addr_q != '0 && prev_addr != open_block && vc_data < min_q) begin
            min_d = vc_data;
            idx_d = prev_addr;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr_q <= '0;
            min_q  <= (PAGE_W+1)'(PAGE_NUM);
            idx_q  <= '0;
        end else begin
            addr_q <= addr_d;
            min_q  <= min_d;
            idx_q  <= idx_d;
        end

endmodule

// File: rtl/gc_ctrl.sv
// gc_ctrl: garbage-collection controller; picks the emptiest block, relocates its valid pages, erases it.
//   clk, rst             : clock, async active-high reset
//   free_blocks          : erased-block count; GC starts below GC_THRESHOLD
//   open_block           : host write block, never a victim
//   host_busy            : host flash traffic pending; GC yields between commands
//   vc_addr / vc_data    : valid-count table read (1-cycle latency)
//   pv_block, pv_page / pv_valid : page-valid bitmap query (1-cycle latency)
//   cmd_req, cmd_op, cmd_block, cmd_page / cmd_ack : command handshake to the flash controller
//   gc_active, gc_done, gc_fail, victim : status
module gc_ctrl
    import nvm_pkg::*;
#(
    parameter int GC_THRESHOLD = GC_THRESHOLD_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W:0]   free_blocks,
    input  logic [BLOCK_W-1:0] open_block,
    input  logic               host_busy,
    output logic [BLOCK_W-1:0] vc_addr,
    input  logic [PAGE_W:0]    vc_data,
    output logic [BLOCK_W-1:0] pv_block,
    output logic [PAGE_W-1:0]  pv_page,
    input  logic               pv_valid,
    output logic               cmd_req,
    output logic [1:0]         cmd_op,
    output logic [BLOCK_W-1:0] cmd_block,
    output logic [PAGE_W-1:0]  cmd_page,
    input  logic               cmd_ack,
    output logic               gc_active,
    output logic               gc_done,
    output logic               gc_fail,
    output logic [BLOCK_W-1:0] victim
);
    gc_state_t          state_q, state_d;
    gc_phase_t          phase_q, phase_d;
    logic [PAGE_W-1:0]  page_q, page_d;
    logic [BLOCK_W-1:0] victim_q, victim_d;
    logic               ret_erase_q, ret_erase_d;
    logic [PAGE_W:0]    min_cnt;
    logic [BLOCK_W-1:0] min_idx;
    logic               scan_done;
    logic               last_page;

    gc_victim_scan u_scan (
        .clk        (clk),
        .rst        (rst),
        .en         (state_q == INI),
        .open_block (open_block),
        .vc_data    (vc_data),
        .vc_addr    (vc_addr),
        .min_cnt    (min_cnt),
        .min_idx    (min_idx),
        .done       (scan_done)
    );

    assign last_page = page_q == PAGE_W'(PAGE_NUM - 1);
    assign gc_active = state_q != IDLE;
    assign victim    = victim_q;
    assign pv_block  = victim_q;
    assign pv_page   = page_q;
    assign cmd_block = cmd_req ? victim_q : '0;
    assign cmd_page  = (cmd_req && state_q == MOVE_START) ? page_q : '0;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        page_d      = page_q;
        victim_d    = victim_q;
        ret_erase_d = ret_erase_q;
        cmd_req     = 1'b0;
        cmd_op      = 2'b00;
        gc_done     = 1'b0;
        gc_fail     = 1'b0;
        case (state_q)
            IDLE:
                if (int'(free_blocks) < GC_THRESHOLD && !host_busy) state_d = INI;
            INI:
                if (scan_done) state_d = INI_DONE;
            INI_DONE: begin
                victim_d = min_idx;
                page_d   = '0;
                phase_d  = PH_QUERY;
                gc_fail  = min_cnt == (PAGE_W+1)'(PAGE_NUM);
                state_d  = gc_fail ? IDLE : MOVE_START;
            end
            MOVE_START:
                if (phase_q == PH_CMD) begin
                    cmd_req = 1'b1;
                    cmd_op  = OP_MOVE;
                    if (cmd_ack) begin
                        phase_d = PH_QUERY;
                        if (last_page) state_d = ERASE;
                        else begin
                            page_d      = page_q + PAGE_W'(1);
                            // Busy that arrived mid-handshake is honoured only now.
                            state_d     = host_busy ? INTERRUPT : MOVE_START;
                            ret_erase_d = 1'b0;
                        end
                    end
                end else if (host_busy) begin
                    state_d     = INTERRUPT;
                    phase_d     = PH_QUERY;
                    ret_erase_d = 1'b0;
                end else if (phase_q == PH_QUERY) phase_d = PH_CHECK;
                else if (pv_valid) phase_d = PH_CMD;
                else begin
                    phase_d = PH_QUERY;
                    if (last_page) state_d = ERASE;
                    else page_d = page_q + PAGE_W'(1);
                end
            ERASE:
                if (phase_q == PH_CMD) begin
                    cmd_req = 1'b1;
                    cmd_op  = OP_ERASE;
                    if (cmd_ack) begin
                        state_d = FINISH;
                        phase_d = PH_QUERY;
                    end
                end else if (host_busy) begin
                    state_d     = INTERRUPT;
                    ret_erase_d = 1'b1;
                end else phase_d = PH_CMD;
            INTERRUPT:
                if (!host_busy) state_d = ret_erase_q ? ERASE : MOVE_START;
            FINISH: begin
                gc_done = 1'b1;
                state_d = IDLE;
            end
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q     <= IDLE;
            phase_q     <= PH_QUERY;
            page_q      <= '0;
            victim_q    <= '0;
            ret_erase_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            page_q      <= page_d;
            victim_q    <= victim_d;
            ret_erase_q <= ret_erase_d;
        end

endmodule

// File: tb/tb_gc_ctrl.sv
// tb_gc_ctrl: randomized self-checking bench for gc_ctrl against a scoreboard of expected commands.
module tb_gc_ctrl;
    import nvm_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [BLOCK_W:0]   free_blocks = 11'd20;
    logic [BLOCK_W-1:0] open_block = '0;
    logic               host_busy = 1'b0;
    logic [BLOCK_W-1:0] vc_addr;
    logic [PAGE_W:0]    vc_data = '0;
    logic [BLOCK_W-1:0] pv_block;
    logic [PAGE_W-1:0]  pv_page;
    logic               pv_valid = 1'b0;
    logic               cmd_req;
    logic [1:0]         cmd_op;
    logic [BLOCK_W-1:0] cmd_block;
    logic [PAGE_W-1:0]  cmd_page;
    logic               cmd_ack = 1'b0;
    logic               gc_active, gc_done, gc_fail;
    logic [BLOCK_W-1:0] victim;

    gc_ctrl dut (
        .clk (clk), .rst (rst), .free_blocks (free_blocks), .open_block (open_block),
        .host_busy (host_busy), .vc_addr (vc_addr), .vc_data (vc_data),
        .pv_block (pv_block), .pv_page (pv_page), .pv_valid (pv_valid),
        .cmd_req (cmd_req), .cmd_op (cmd_op), .cmd_block (cmd_block), .cmd_page (cmd_page),
        .cmd_ack (cmd_ack), .gc_active (gc_active), .gc_done (gc_done), .gc_fail (gc_fail),
        .victim (victim)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [PAGE_W:0]    vc_mem [BLOCK_NUM];
    logic [PAGE_NUM-1:0] pv_mem;
    logic [BLOCK_W-1:0] cur_vic = '0;
    int mode = 0;
    bit kill_erase = 1'b0;
    int dir_st = 0, dir_cnt = 0;
    logic was_req = 1'b0, ack_pend = 1'b0;
    logic [17:0] last_cmd = '0;
    logic [17:0] obs_q[$];
    logic [17:0] exp_q[$];
    int done_cnt = 0, fail_cnt = 0, vc_act = 0, act_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [57:0] outs();
        return {cmd_req, cmd_op, cmd_block, cmd_page, vc_addr, pv_block, pv_page, victim,
                gc_active, gc_done, gc_fail};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Table memories with one-cycle read latency.
    always @(posedge clk) begin
        vc_data  <= vc_mem[vc_addr];
        pv_valid <= (pv_block == cur_vic) && pv_mem[pv_page];
    end

    always @(negedge clk)
        if (!rst) begin
            if (gc_done) done_cnt++;
            if (gc_fail) fail_cnt++;
            if (vc_addr != '0) vc_act++;
            if (gc_active) act_cnt++;
        end

    // Flash-controller / host responder and handshake protocol checks.
    always @(negedge clk)
        if (rst) begin
            cmd_ack = 1'b0; was_req = 1'b0; ack_pend = 1'b0; host_busy = 1'b0;
            dir_st = 0; dir_cnt = 0;
        end else begin
            if (ack_pend) chk("req_drop", cmd_req, 0);
            if (cmd_req && was_req && !ack_pend) chk("cmd_stable", {cmd_op, cmd_block, cmd_page}, last_cmd);
            if (cmd_req && !was_req) chk("yield", host_busy, 0);
            case (mode)
                1: host_busy = ($urandom_range(0, 5) == 0);
                2:
                    if (dir_st == 0 && cmd_req && cmd_op == OP_MOVE && cmd_page == 6'd5) begin
                        host_busy = 1'b1;
                        dir_st = 1;
                        dir_cnt = 0;
                    end else if (dir_st == 2) begin
                        chk("intr_hold", {cmd_req, gc_active, pv_page}, {1'b0, 1'b1, 6'd6});
                        dir_cnt++;
                        if (dir_cnt == 6) begin
                            host_busy = 1'b0;
                            dir_st = 3;
                        end
                    end
                default: host_busy = 1'b0;
            endcase
            if (mode == 2 && dir_st == 1) begin
                dir_cnt++;
                cmd_ack = cmd_req && dir_cnt > 3;
                if (cmd_ack) begin
                    dir_st = 2;
                    dir_cnt = 0;
                end
            end else if (cmd_req)
                cmd_ack = (kill_erase && cmd_op == OP_ERASE) ? 1'b0 : ($urandom_range(0, 2) == 0);
            else
                cmd_ack = ($urandom_range(0, 7) == 0);
            ack_pend = cmd_req && cmd_ack;
            if (ack_pend) obs_q.push_back({cmd_op, cmd_block, (cmd_op == OP_ERASE) ? 6'd0 : cmd_page});
            was_req = cmd_req;
            last_cmd = {cmd_op, cmd_block, cmd_page};
        end

    // Reference: emptiest non-open block (first on ties) unless every candidate is full;
    // then one MOVE per valid page in ascending order followed by one ERASE.
    task automatic run_gc(input string tag, input int md, input bit kill);
        int m = PAGE_NUM;
        int vic = 0;
        bit fl;
        int d0 = done_cnt, f0 = fail_cnt, n = 0;
        for (int b = 0; b < BLOCK_NUM; b++)
            if (b != int'(open_block) && int'(vc_mem[b]) < m) begin
                m = int'(vc_mem[b]);
                vic = b;
            end
        fl = (m == PAGE_NUM);
        exp_q.delete();
        if (!fl) begin
            for (int p = 0; p < PAGE_NUM; p++)
                if (pv_mem[p]) exp_q.push_back({OP_MOVE, 10'(vic), 6'(p)});
            exp_q.push_back({OP_ERASE, 10'(vic), 6'd0});
        end
        cur_vic = 10'(vic);
        obs_q.delete();
        mode = md;
        kill_erase = kill;
        free_blocks = 11'd15;
        while (!gc_active && n < 300) begin step(); n++; end
        chk({tag, "_start"}, gc_active, 1);
        free_blocks = 11'd20;
        if (kill) begin
            n = 0;
            while (!(cmd_req && cmd_op == OP_ERASE) && n < 30000) begin step(); n++; end
            chk({tag, "_erase_seen"}, cmd_req && cmd_op == OP_ERASE, 1);
            rst = 1'b1;
            #1;
            chk({tag, "_rst_outs"}, outs(), 0);
            chk({tag, "_n_moves"}, obs_q.size(), exp_q.size() - 1);
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk({tag, "_cmd"}, obs_q[i], exp_q[i]);
            repeat (3) step();
            chk({tag, "_rst_hold"}, outs(), 0);
            rst = 1'b0;
            mode = 0;
            kill_erase = 1'b0;
            repeat (5) step();
            chk({tag, "_post_rst"}, outs(), 0);
            return;
        end
        n = 0;
        while (done_cnt == d0 && fail_cnt == f0 && n < 30000) begin step(); n++; end
        mode = 0;
        repeat (5) step();
        chk({tag, "_done"}, done_cnt - d0, fl ? 0 : 1);
        chk({tag, "_fail"}, fail_cnt - f0, fl ? 1 : 0);
        chk({tag, "_idle"}, gc_active, 0);
        chk({tag, "_n_cmds"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk({tag, "_cmd"}, obs_q[i], exp_q[i]);
        if (!fl) chk({tag, "_victim"}, victim, vic);
    endtask

    task automatic directed_table();
        for (int b = 0; b < BLOCK_NUM; b++) vc_mem[b] = 7'd64;
        vc_mem[7] = 7'd3;
        vc_mem[9] = 7'd3;
        open_block = 10'd100;
        pv_mem = '0;
        pv_mem[0] = 1'b1;
        pv_mem[5] = 1'b1;
        pv_mem[63] = 1'b1;
    endtask

    initial begin
        int a0, v0;
        for (int b = 0; b < BLOCK_NUM; b++) vc_mem[b] = 7'd64;
        pv_mem = '0;
        repeat (3) step();
        chk("rst_outs", outs(), 0);
        rst = 1'b0;
        step();
        chk("post_rst_outs", outs(), 0);

        a0 = act_cnt; v0 = vc_act;
        free_blocks = 11'd20;
        repeat (40) step();
        free_blocks = 11'd16;
        repeat (40) step();
        chk("thr_no_vc", vc_act - v0, 0);
        chk("thr_no_active", act_cnt - a0, 0);

        directed_table();
        run_gc("dir", 2, 1'b0);
        chk("dir_resumed", dir_st, 3);

        for (int b = 0; b < BLOCK_NUM; b++) vc_mem[b] = 7'd64;
        vc_mem[0] = 7'd0;
        open_block = 10'd0;
        run_gc("allfull", 0, 1'b0);

        for (int r = 0; r < 4; r++) begin
            int x, y;
            for (int b = 0; b < BLOCK_NUM; b++)
                vc_mem[b] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(4, 64)) : 7'd64;
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
            vc_mem[x] = 7'($urandom_range(1, 4));
            vc_mem[y] = vc_mem[x];
            open_block = 10'($urandom_range(0, 1023));
            vc_mem[open_block] = 7'd0;
            for (int p = 0; p < PAGE_NUM; p++) pv_mem[p] = ($urandom_range(0, 3) == 0);
            run_gc("rand", (r % 2 == 0) ? 1 : 0, 1'b0);
        end

        directed_table();
        run_gc("kill", 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
